extender: RTL and testbench

- Immediate generator for the RV32I datapath; sits between instruction fetch/decode and the ALU/branch-target adders.
- Takes instruction bits [31:7] and a 3-bit immediate-format select from the control unit.
- Produces a 32-bit sign- or zero-filled immediate combinationally, plus a registered copy for pipelined use.

---
 rtl/extender.sv | 48 ++++
 tb/tb_extender.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/extender.sv
// RV32I immediate generator: combinational immext/illegal plus an enable-gated registered copy.
// Registered path has 1-cycle latency, holds while en=0, and never captures X (illegal stores zero).
module extender (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:7] instr,
  input  logic [2:0]  immsrc,
  output logic [31:0] immext,
  output logic        illegal,
  output logic [31:0] immext_q,
  output logic        illegal_q
);

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  always_comb begin
    immext  = 'x;
    illegal = 1'b0;
    case (immsrc)
      IMM_I: immext = {{20{instr[31]}}, instr[31:20]};
      IMM_S: immext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: immext = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J: immext = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U: immext = {instr[31:12], 12'b0};
      default: begin
        // Unused select codes leave the value as don't-care and flag it.
        immext  = 'x;
        illegal = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      immext_q  <= 32'h0;
      illegal_q <= 1'b0;
    end else if (en) begin
      immext_q  <= illegal ? 32'h0 : immext;
      illegal_q <= illegal;
    end
  end

endmodule

// File: tb/tb_extender.sv
// Directed bench for extender: each immediate format, illegal selects, register enable and async reset.
module tb_extender;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:7] instr;
  logic [2:0]  immsrc;
  logic [31:0] immext;
  logic        illegal;
  logic [31:0] immext_q;
  logic        illegal_q;

  int checks   = 0;
  int failures = 0;
  logic four_state;

  extender dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .instr     (instr),
    .immsrc    (immsrc),
    .immext    (immext),
    .illegal   (illegal),
    .immext_q  (immext_q),
    .illegal_q (illegal_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    en = 1'b1;
    instr = '0;
    instr[31:20] = 12'hFFC;
    immsrc = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (immext_q !== 32'h0) begin
      failures++;
      $display("FAIL reset_immext_q: got %h expected %h", immext_q, 32'h0);
    end
    checks++;
    if (illegal_q !== 1'b0) begin
      failures++;
      $display("FAIL reset_illegal_q: got %b expected 0", illegal_q);
    end
    checks++;
    if (immext !== 32'hFFFFFFFC) begin
      failures++;
      $display("FAIL reset_comb_immext: got %h expected %h", immext, 32'hFFFFFFFC);
    end
    @(negedge clk);
    immsrc = 3'b111;
    @(posedge clk);
    #1;
    checks++;
    if (illegal_q !== 1'b0) begin
      failures++;
      $display("FAIL reset_illegal_q_hold: got %b expected 0", illegal_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0;
    immsrc = 3'b000;
  endtask

  task automatic test_itype;
    logic [11:0] imm [4] = '{12'h004, 12'hFFC, 12'h7FF, 12'h800};
    logic [31:0] exp [4] = '{32'h00000004, 32'hFFFFFFFC, 32'h000007FF, 32'hFFFFF800};
    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < 3; r++) begin
        @(negedge clk);
        immsrc = 3'b000;
        instr = '0;
        instr[31:20] = imm[k];
        if (r > 0) instr[19:7] = 13'($urandom);
        #1;
        checks++;
        if (immext !== exp[k] || illegal !== 1'b0) begin
          failures++;
          $display("FAIL itype_%0d_%0d: got %h/%b expected %h/0", k, r, immext, illegal, exp[k]);
        end
      end
    end
  endtask

  task automatic test_stype;
    logic [6:0]  hi  [2] = '{7'h00, 7'h7F};
    logic [4:0]  lo  [2] = '{5'b00100, 5'b11100};
    logic [31:0] exp [2] = '{32'h00000004, 32'hFFFFFFFC};
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 3; r++) begin
        @(negedge clk);
        immsrc = 3'b001;
        instr = '0;
        instr[31:25] = hi[k];
        instr[11:7]  = lo[k];
        if (r > 0) instr[24:12] = 13'($urandom);
        #1;
        checks++;
        if (immext !== exp[k]) begin
          failures++;
          $display("FAIL stype_%0d_%0d: got %h expected %h", k, r, immext, exp[k]);
        end
      end
    end
  endtask

  task automatic test_btype;
    logic [6:0]  hi  [3] = '{7'h00, 7'h7F, 7'h00};
    logic [4:0]  lo  [3] = '{5'b00100, 5'b11101, 5'b00001};
    // Third vector isolates instr[7] landing on bit 11.
    logic [31:0] exp [3] = '{32'h00000004, 32'hFFFFFFFC, 32'h00000800};
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 2; r++) begin
        @(negedge clk);
        immsrc = 3'b010;
        instr = '0;
        instr[31:25] = hi[k];
        instr[11:7]  = lo[k];
        if (r > 0) instr[24:12] = 13'($urandom);
        #1;
        checks++;
        if (immext !== exp[k]) begin
          failures++;
          $display("FAIL btype_%0d_%0d: got %h expected %h", k, r, immext, exp[k]);
        end
      end
    end
  endtask

  task automatic test_jtype;
    logic [19:0] f   [3] = '{20'h00800, 20'hFF9FF, 20'h00100};
    // Third vector isolates instr[20] landing on bit 11.
    logic [31:0] exp [3] = '{32'h00000008, 32'hFFFFFFF8, 32'h00000800};
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 2; r++) begin
        @(negedge clk);
        immsrc = 3'b011;
        instr = '0;
        instr[31:12] = f[k];
        if (r > 0) instr[11:7] = 5'($urandom);
        #1;
        checks++;
        if (immext !== exp[k]) begin
          failures++;
          $display("FAIL jtype_%0d_%0d: got %h expected %h", k, r, immext, exp[k]);
        end
      end
    end
  endtask

  task automatic test_utype;
    logic [19:0] f   [2] = '{20'h00001, 20'hFFFFF};
    logic [31:0] exp [2] = '{32'h00001000, 32'hFFFFF000};
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 2; r++) begin
        @(negedge clk);
        immsrc = 3'b100;
        instr = '0;
        instr[31:12] = f[k];
        if (r > 0) instr[11:7] = 5'($urandom);
        #1;
        checks++;
        if (immext !== exp[k]) begin
          failures++;
          $display("FAIL utype_%0d_%0d: got %h expected %h", k, r, immext, exp[k]);
        end
      end
    end
  endtask

  task automatic test_register;
    @(negedge clk);
    instr = '0;
    instr[31:20] = 12'hFFC;
    immsrc = 3'b000;
    en = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (immext_q !== 32'hFFFFFFFC || illegal_q !== 1'b0) begin
      failures++;
      $display("FAIL reg_capture: got %h/%b expected fffffffc/0", immext_q, illegal_q);
    end
    @(negedge clk);
    en = 1'b0;
    instr = '0;
    instr[31:12] = 20'hFFFFF;
    immsrc = 3'b100;
    #1;
    checks++;
    if (immext !== 32'hFFFFF000) begin
      failures++;
      $display("FAIL reg_comb_update: got %h expected fffff000", immext);
    end
    @(posedge clk);
    #1;
    checks++;
    if (immext_q !== 32'hFFFFFFFC) begin
      failures++;
      $display("FAIL reg_hold: got %h expected fffffffc", immext_q);
    end
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (immext_q !== 32'hFFFFF000) begin
      failures++;
      $display("FAIL reg_reload: got %h expected fffff000", immext_q);
    end
    @(negedge clk);
    instr = '0;
    instr[31:20] = 12'h004;
    immsrc = 3'b000;
    #2;
    instr[31:20] = 12'h7FF;
    @(posedge clk);
    #1;
    checks++;
    if (immext_q !== 32'h000007FF) begin
      failures++;
      $display("FAIL reg_edge_value: got %h expected 000007ff", immext_q);
    end
    @(negedge clk);
    en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (immext_q !== 32'h0 || illegal_q !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got %h/%b expected 00000000/0", immext_q, illegal_q);
    end
    checks++;
    if (immext !== 32'h000007FF) begin
      failures++;
      $display("FAIL async_reset_comb: got %h expected 000007ff", immext);
    end
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (immext_q !== 32'h000007FF) begin
      failures++;
      $display("FAIL reset_release_capture: got %h expected 000007ff", immext_q);
    end
  endtask

  task automatic test_illegal;
    @(negedge clk);
    instr = '0;
    immsrc = 3'b111;
    en = 1'b1;
    #1;
    checks++;
    if (illegal !== 1'b1) begin
      failures++;
      $display("FAIL illegal_flag_111: got %b expected 1", illegal);
    end
    if (four_state) begin
      checks++;
      if (immext !== 32'hxxxxxxxx) begin
        failures++;
        $display("FAIL illegal_immext_x: got %h expected xxxxxxxx", immext);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (immext_q !== 32'h0 || illegal_q !== 1'b1) begin
      failures++;
      $display("FAIL illegal_capture: got %h/%b expected 00000000/1", immext_q, illegal_q);
    end
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      instr = 25'($urandom);
      immsrc = 3'(c);
      #1;
      checks++;
      if (illegal !== (c >= 5)) begin
        failures++;
        $display("FAIL illegal_code_%0d: got %b expected %b", c, illegal, (c >= 5));
      end
    end
    @(negedge clk);
    instr = '0;
    instr[31:12] = 20'h00001;
    immsrc = 3'b100;
    @(posedge clk);
    #1;
    checks++;
    if (immext_q !== 32'h00001000 || illegal_q !== 1'b0) begin
      failures++;
      $display("FAIL illegal_clear: got %h/%b expected 00001000/0", immext_q, illegal_q);
    end
  endtask

  initial begin
    logic probe;
    probe = 1'bx;
    four_state = (probe === 1'bx);
    rst_n = 1'b0;
    en = 1'b0;
    instr = '0;
    immsrc = 3'b000;
    test_reset;
    test_itype;
    test_stype;
    test_btype;
    test_jtype;
    test_utype;
    test_register;
    test_illegal;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
